counter_arbiter: RTL and testbench
==================================

// Module: counter_arbiter
// PURPOSE
//  Two-requester round-robin arbiter sharing a single wrapping counter between
//  req1 and req2. Grants one requester at a time, bounds each grant to MAX_HOLD
//  cycles and increments the shared counter on every granted cycle. Formal
//  targets (ebmc) check mutual exclusion and the counter bound.
// PARAMETERS
//  CNT_W     17        counter width (bits)
//  RST_VAL   1<<12     wrap value; counter is always < RST_VAL
//  MAX_HOLD  8         max consecutive granted cycles per grant (>=1)
// PORTS
//  clk     in   1      clock, all state updates on posedge
//  rst     in   1      asynchronous, active-high reset
//  req1    in   1      request from requester 1 (level, held until done)
//  req2    in   1      request from requester 2
//  gnt1    out  1      grant to requester 1
//  gnt2    out  1      grant to requester 2
//  enable  out  1      counter advancing this cycle (= gnt1 | gnt2)
//  out     out  CNT_W  shared counter value
// BEHAVIOUR
//  - Reset (async, active-high): state=IDLE, out=0, hold_cnt=0, last=2;
//    gnt1=gnt2=enable=0 while rst high and first cycle after.
//  - States IDLE, GNT1, GNT2; gnt1=(state==GNT1), gnt2=(state==GNT2), decoded
//    from state reg (no combinational path req->gnt). Grant latency: 1 cycle.
//  - IDLE: req1&!req2 -> GNT1; req2&!req1 -> GNT2; both -> grant requester
//    not equal to last (last=2 after reset, so req1 wins first tie); none -> IDLE.
//  - GNTx: release when !reqx OR hold_cnt==MAX_HOLD-1. On release: other req
//    high -> GNTother (direct handover, no idle gap); else -> IDLE. Not
//    released -> stay, hold_cnt+1. last<=x on entering GNTx.
//  - hold_cnt=0 on every grant entry and in IDLE; never reaches MAX_HOLD.
//  - Forced release with only reqx high: IDLE one cycle, then re-grant x.
//  - Counter: each posedge with enable=1: out<=(out==RST_VAL-1)?0:out+1.
//    Unchanged when enable=0. Increment computed CNT_W+1 bits, no overflow.
//  - Reset mid-grant: grant drops immediately (async), out cleared.
//  - Invariants: !(gnt1&gnt2); out<RST_VAL; hold_cnt<MAX_HOLD.
// CONFIGURATION
//  COUNTER_ARB_ASSERT_EN defined: module contains assert property for the
//   three invariants above plus (req1&req2&gnt1) -> next state !GNT1 after
//   MAX_HOLD cycles (no starvation). Undefined: no assertions; RTL identical.
// STRUCTURE
//  counter_arb_pkg: state_t enum {IDLE,GNT1,GNT2}, requester id typedef,
//   default CNT_W/RST_VAL/MAX_HOLD localparams.
//  Sub-module arb_wrap_counter (CNT_W, RST_VAL; clk, rst, enable -> out):
//   wrapping counter only; FSM and hold logic stay in counter_arbiter.
// TESTING
//  1 rst pulse mid-grant -> gnt1=gnt2=0, out=0 same cycle; IDLE after release.
//  2 req1 only, held 3 cycles then dropped -> gnt1 for 3 cycles, out 0->3.
//  3 req1,req2 both from reset -> gnt1 first 8 cycles, then gnt2 8 cycles,
//    alternating; never both high; out=16 after 16 granted cycles.
//  4 req2 held alone 20 cycles, MAX_HOLD=8 -> 8 gnt2, 1 idle, 8 gnt2, 1 idle.
//  5 preload RST_VAL=4 build, req1 held 6 cycles -> out 1,2,3,0,1,2.
//  6 formal with COUNTER_ARB_ASSERT_EN: ebmc proves all asserts, bound 20.

Source files
------------

// File: rtl/counter_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_arb_pkg
// Description : Shared types and default parameters for the counter arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_arb_pkg;

    localparam int c_CNT_W_DEF    = 17;
    localparam int c_RST_VAL_DEF  = 1 << 12;
    localparam int c_MAX_HOLD_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT1 = 2'd1,
        GNT2 = 2'd2
    } state_t;

    typedef logic [1:0] req_id_t;

    localparam req_id_t c_REQ1 = 2'd1;
    localparam req_id_t c_REQ2 = 2'd2;

endpackage
`default_nettype wire

// File: rtl/arb_wrap_counter.sv
`default_nettype none
// ============================================================================
// Module      : arb_wrap_counter
// Description : Counter that advances on enable and wraps to 0 at RST_VAL.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_wrap_counter #(
    parameter int CNT_W   = 17,
    parameter int RST_VAL = 1 << 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic [CNT_W-1:0] out
);

    localparam logic [CNT_W:0] c_WRAP_AT = (CNT_W + 1)'(RST_VAL);

    logic [CNT_W-1:0] r_out;
    logic [CNT_W:0]   w_inc;

    // One extra bit so the increment can never overflow before the wrap test.
    assign w_inc = {1'b0, r_out} + (CNT_W + 1)'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= '0;
        end else if (enable) begin
            if (w_inc == c_WRAP_AT) begin
                r_out <= '0;
            end else begin
                r_out <= w_inc[CNT_W-1:0];
            end
        end
    end

    assign out = r_out;

endmodule
`default_nettype wire

// File: rtl/counter_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : counter_arbiter
// Description : Two-requester round-robin arbiter with bounded grant length
//               driving a shared wrapping counter.
//               Optional macro COUNTER_ARB_ASSERT_EN adds invariant properties.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_arbiter
    import counter_arb_pkg::*;
#(
    parameter int CNT_W    = c_CNT_W_DEF,
    parameter int RST_VAL  = c_RST_VAL_DEF,
    parameter int MAX_HOLD = c_MAX_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req1,
    input  logic             req2,
    output logic             gnt1,
    output logic             gnt2,
    output logic             enable,
    output logic [CNT_W-1:0] out
);

    localparam int c_HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(MAX_HOLD - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_HOLD_W-1:0] r_hold;
    logic [c_HOLD_W-1:0] w_hold_nxt;
    req_id_t             r_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_last  <= c_REQ2;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            if (w_state_nxt == GNT1) begin
                r_last <= c_REQ1;
            end else if (w_state_nxt == GNT2) begin
                r_last <= c_REQ2;
            end
        end
    end

    // On release the other requester is served directly when it is waiting.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (req1 && (!req2 || (r_last != c_REQ1))) begin
                    w_state_nxt = GNT1;
                end else if (req2) begin
                    w_state_nxt = GNT2;
                end
            end
            GNT1: begin
                if (!req1 || (r_hold == c_HOLD_LAST)) begin
                    w_state_nxt = req2 ? GNT2 : IDLE;
                end
            end
            GNT2: begin
                if (!req2 || (r_hold == c_HOLD_LAST)) begin
                    w_state_nxt = req1 ? GNT1 : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_hold_nxt = ((w_state_nxt == r_state) && (r_state != IDLE))
                   ? r_hold + c_HOLD_W'(1) : '0;
    end

    always_comb begin
        gnt1   = (r_state == GNT1);
        gnt2   = (r_state == GNT2);
        enable = (r_state == GNT1) || (r_state == GNT2);
    end

    arb_wrap_counter #(
        .CNT_W   (CNT_W),
        .RST_VAL (RST_VAL)
    ) u_counter (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .out    (out)
    );

`ifdef COUNTER_ARB_ASSERT_EN
    a_mutex: assert property (@(posedge clk) disable iff (rst) !(gnt1 && gnt2));
    a_out_bound: assert property (@(posedge clk) disable iff (rst)
        out <= CNT_W'(RST_VAL - 1));
    a_hold_bound: assert property (@(posedge clk) disable iff (rst)
        r_hold <= c_HOLD_LAST);
    a_no_starve: assert property (@(posedge clk) disable iff (rst)
        (req1 && req2 && gnt1) |-> ##[1:MAX_HOLD] (r_state != GNT1));
`else
    // Invariant properties are compiled only when the macro is defined.
`endif

endmodule
`default_nettype wire

// File: tb/tb_counter_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_arbiter
// Description : Directed self-checking bench for counter_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req1 = 1'b0;
    logic        req2 = 1'b0;
    logic        gnt1, gnt2, enable;
    logic [16:0] out;

    logic        req1b = 1'b0;
    logic        req2b = 1'b0;
    logic        gnt1b, gnt2b, enableb;
    logic [16:0] outb;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    counter_arbiter dut (
        .clk    (clk),
        .rst    (rst),
        .req1   (req1),
        .req2   (req2),
        .gnt1   (gnt1),
        .gnt2   (gnt2),
        .enable (enable),
        .out    (out)
    );

    // Small-wrap build for the wrap-around check.
    counter_arbiter #(.RST_VAL(4)) dut4 (
        .clk    (clk),
        .rst    (rst),
        .req1   (req1b),
        .req2   (req2b),
        .gnt1   (gnt1b),
        .gnt2   (gnt2b),
        .enable (enableb),
        .out    (outb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        logic eg;

        // reset state
        #2 rst = 1'b1;
        #2;
        chk("rst_gnt1", {31'b0, gnt1}, 32'd0);
        chk("rst_gnt2", {31'b0, gnt2}, 32'd0);
        chk("rst_en", {31'b0, enable}, 32'd0);
        chk("rst_out", {15'b0, out}, 32'd0);
        tick();
        rst = 1'b0;
        chk("post_rst_gnt1", {31'b0, gnt1}, 32'd0);
        tick();
        chk("idle_gnt1", {31'b0, gnt1}, 32'd0);
        chk("idle_out", {15'b0, out}, 32'd0);

        // req1 alone for three granted cycles
        req1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("r1_gnt1", {31'b0, gnt1}, 32'd1);
            chk("r1_en", {31'b0, enable}, 32'd1);
            chk("r1_out", {15'b0, out}, k);
        end
        req1 = 1'b0;
        tick();
        chk("r1_rel_gnt1", {31'b0, gnt1}, 32'd0);
        chk("r1_rel_out", {15'b0, out}, 32'd3);

        // reset in the middle of a grant
        req1 = 1'b1;
        tick();
        chk("mid_gnt1", {31'b0, gnt1}, 32'd1);
        tick();
        chk("mid_out", {15'b0, out}, 32'd4);
        rst = 1'b1;
        #1;
        chk("mid_rst_gnt1", {31'b0, gnt1}, 32'd0);
        chk("mid_rst_out", {15'b0, out}, 32'd0);
        tick();
        rst = 1'b0;
        req1 = 1'b0;
        tick();
        chk("mid_idle_gnt1", {31'b0, gnt1}, 32'd0);
        chk("mid_idle_gnt2", {31'b0, gnt2}, 32'd0);

        // both requesting from reset: alternate 8-cycle grants, req1 first
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req1 = 1'b1;
        req2 = 1'b1;
        for (int k = 0; k < 32; k++) begin
            tick();
            chk("rr_gnt1", {31'b0, gnt1}, ((k / 8) % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_gnt2", {31'b0, gnt2}, ((k / 8) % 2 == 1) ? 32'd1 : 32'd0);
            chk("rr_mutex", {31'b0, gnt1 & gnt2}, 32'd0);
            chk("rr_out", {15'b0, out}, k);
        end
        req1 = 1'b0;
        req2 = 1'b0;

        // req2 alone: forced release gives one idle cycle every 9
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req2 = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            eg = (k % 9) != 8;
            chk("r2_gnt2", {31'b0, gnt2}, {31'b0, eg});
            chk("r2_gnt1", {31'b0, gnt1}, 32'd0);
            chk("r2_out", {15'b0, out}, cnt);
            if (eg) cnt++;
        end
        req2 = 1'b0;

        // wrap at RST_VAL=4
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req1b = 1'b1;
        tick();
        chk("wrap_gnt1", {31'b0, gnt1b}, 32'd1);
        chk("wrap_out0", {15'b0, outb}, 32'd0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("wrap_out", {15'b0, outb}, k % 4);
        end
        req1b = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
